div16by8: RTL and testbench
===========================

# div16by8

Sequential 16-bit by 8-bit unsigned restoring divider, the inverse datapath of the 8-bit shift-add multiplier. It takes a 16-bit dividend, such as the multiplier's `d_out` product, and an 8-bit divisor. It produces a 16-bit quotient and an 8-bit remainder, one quotient bit per clock. It shares the multiplier's `start` / `locked` / `done_flag` handshake and 3-bit state code, so it drops into the same top level and seven-segment controller.

## Interface
- Parameters: none. Widths are fixed at 16/8 to mate with the multiplier product and operands.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  level; sampled only in IDLE.
- `dividend`  in  16  unsigned dividend, captured on the start edge.
- `divisor`  in  8  unsigned divisor, captured on the start edge.
- `quotient`  out  16  registered result; holds the last result until the next DONE.
- `remainder`  out  8  registered result; same hold rule as `quotient`.
- `locked`  out  1  high while an operation is in flight; operands are frozen.
- `done_flag`  out  1  one-cycle pulse when results update.
- `div_by_zero`  out  1  sticky flag for the last operation; only active with the macro.
- `state`  out  3  FSM code for the seven-segment controller.
- `verif_dividend`  out  16  captured-dividend copy, for bench checking.
- `verif_divisor`  out  8  captured-divisor copy, for bench checking.

## Operation
- **States and codes:** IDLE=0, CALC=1, DONE=2. Codes 3–7 are unused and decode to IDLE.
- **IDLE:**
  - On `start`=1: capture operands into internal registers.
  - Clear the 9-bit partial remainder `r` and the 5-bit counter `cnt`.
  - Load the quotient shift register `q` with the dividend.
  - Set `locked`=1 and go to CALC.
- **CALC iteration**, once per cycle:
  - `t = {r[7:0], q[15]}` (9 bits).
  - If `t >= {1'b0, divisor}`: `r = t - divisor`, shift 1 into `q` LSB.
  - Else: `r = t`, shift 0 into `q` LSB.
  - `cnt` increments each iteration.
  - After the 16th iteration (`cnt`==15 in that cycle), go to DONE.
- **DONE:**
  - Load `q` into `quotient` and `r[7:0]` into `remainder`.
  - `done_flag`=1 for this cycle only.
  - Next edge: `locked`=0, go to IDLE.
- **Busy behaviour:** `start` is ignored outside IDLE. Changes to `dividend`/`divisor` while `locked` have no effect.
- **Held high:** if `start` is still high in IDLE after DONE, a new operation begins immediately, on the same operands if they are unchanged.
- **Arithmetic:** all arithmetic is unsigned. The remainder always satisfies `remainder < divisor` when `divisor` != 0.
- **Zero divisor without the macro:** restoring division yields quotient 0xFFFF and remainder = `dividend[7:0]`.
- **Reset, at any time including mid-CALC:**
  - State goes to IDLE.
  - All outputs and internal registers clear to 0: `quotient`=0, `remainder`=0, `locked`=0, `done_flag`=0, `div_by_zero`=0, `state`=0, `verif_*`=0.

## Timing
- Call the edge that samples `start` in IDLE "edge 0".
- `locked` goes high after edge 0.
- CALC occupies edges 1–16.
- DONE is entered after edge 16:
  - `done_flag`, `quotient` and `remainder` are valid from edge 16 to edge 17.
  - `quotient` and `remainder` remain valid until the next DONE.
- IDLE resumes after edge 17.
- Throughput: one division per 18 cycles with `start` held high.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `DIV16BY8_ZERO_DETECT_EN`.
- **Defined:**
  - In IDLE, a captured divisor of 0 skips CALC and goes straight to DONE.
  - DONE is entered after edge 0, so `done_flag` is high from edge 0 to edge 1.
  - Results are `quotient`=0xFFFF and `remainder`=`dividend[7:0]`.
  - `div_by_zero`=1, held until the next operation's DONE or reset.
- **Undefined:**
  - `div_by_zero` is tied to 0.
  - A zero divisor runs the full 16 iterations and produces the same result values.

## Structure
- **Package `div_pkg`:**
  - state encoding constants (IDLE/CALC/DONE)
  - `DIVIDEND_W`=16, `DIVISOR_W`=8
  - `ITER_LAST`=15
- **Sub-module `div_step`:**
  - Purely combinational, one restoring iteration.
  - Inputs: `r_in[7:0]`, `bit_in`, `divisor`.
  - Outputs: `r_out[7:0]`, `q_bit`.
- The top FSM, counter and registers live in `div16by8`.

## Test plan
- **Nominal division:** `dividend`=39483, `divisor`=200 → `quotient`=197, `remainder`=83. `done_flag` is high exactly one cycle, 16 edges after the start edge.
- **Divide by 1:** 65535/1 → 65535 r 0.
- **Exact multiple:** 0xFFFF/0xFF → 257 r 0.
- **Dividend smaller than divisor:** 100/255 → 0 r 100.
- **Zero divisor:** 1234/0 → `quotient`=0xFFFF, `remainder`=0xD2.
  - With the macro: `div_by_zero`=1 and `done_flag` one edge after start.
  - Without the macro: `div_by_zero`=0 and `done_flag` at edge 16.
- **Interference:**
  - Change operands and pulse `start` mid-CALC → result unaffected, `verif_*` unchanged.
  - Assert `rst` at edge 8 of CALC → all outputs 0 immediately, state IDLE.
  - A subsequent 500/7 → 71 r 3.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the 16-by-8 restoring divider.
// Pure declarations; no latency or flow control of its own.
// Imported by div_step and div16by8.
package div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int ITER_LAST  = 15;
    localparam int CNT_W      = 5;

    // Codes match the multiplier so the seven-segment controller decodes both.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_DONE = 3'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational, zero cycles.
// Backpressure: none; evaluated every cycle by the parent FSM.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] r_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] r_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] w_t;

    assign w_t   = {r_in, bit_in};
    assign q_bit = (w_t >= {1'b0, divisor});
    // When the subtract is taken the true difference is below 256, so 8-bit wraparound is exact.
    assign r_out = q_bit ? (w_t[DIVISOR_W-1:0] - divisor) : w_t[DIVISOR_W-1:0];

endmodule

// File: rtl/div16by8.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock; DIV16BY8_ZERO_DETECT_EN short-cuts a zero divisor.
// Latency: done_flag 16 edges after the start edge (0 edges for a detected zero divisor); 18-cycle throughput.
// Backpressure: start is only sampled in IDLE; operands are frozen while locked.
module div16by8
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  locked,
    output logic                  done_flag,
    output logic                  div_by_zero,
    output logic [2:0]            state,
    output logic [DIVIDEND_W-1:0] verif_dividend,
    output logic [DIVISOR_W-1:0]  verif_divisor
);

    state_t                r_state;
    logic [DIVIDEND_W-1:0] r_dividend;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVIDEND_W-1:0] r_q;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_locked;
    logic                  r_done_flag;

    logic [DIVISOR_W-1:0]  w_r_next;
    logic                  w_q_bit;

    div_step u_step (
        .r_in    (r_rem),
        .bit_in  (r_q[DIVIDEND_W-1]),
        .divisor (r_divisor),
        .r_out   (w_r_next),
        .q_bit   (w_q_bit)
    );

`ifdef DIV16BY8_ZERO_DETECT_EN
    logic r_div_by_zero;
    assign div_by_zero = r_div_by_zero;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_locked    <= 1'b0;
            r_done_flag <= 1'b0;
`ifdef DIV16BY8_ZERO_DETECT_EN
            r_div_by_zero <= 1'b0;
`endif
        end else begin
            r_done_flag <= 1'b0;
            case (r_state)
                ST_CALC: begin
                    r_rem <= w_r_next;
                    r_q   <= {r_q[DIVIDEND_W-2:0], w_q_bit};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == CNT_W'(ITER_LAST)) begin
                        r_state     <= ST_DONE;
                        r_quotient  <= {r_q[DIVIDEND_W-2:0], w_q_bit};
                        r_remainder <= w_r_next;
                        r_done_flag <= 1'b1;
`ifdef DIV16BY8_ZERO_DETECT_EN
                        r_div_by_zero <= 1'b0;
`endif
                    end
                end
                ST_DONE: begin
                    r_locked <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                // IDLE, and the unused codes which behave as IDLE.
                default: begin
                    r_state <= ST_IDLE;
                    if (start) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_q        <= dividend;
                        r_locked   <= 1'b1;
`ifdef DIV16BY8_ZERO_DETECT_EN
                        if (divisor == '0) begin
                            r_state       <= ST_DONE;
                            r_quotient    <= '1;
                            r_remainder   <= dividend[DIVISOR_W-1:0];
                            r_done_flag   <= 1'b1;
                            r_div_by_zero <= 1'b1;
                        end else begin
                            r_state <= ST_CALC;
                        end
`else
                        r_state <= ST_CALC;
`endif
                    end
                end
            endcase
        end
    end

    assign quotient       = r_quotient;
    assign remainder      = r_remainder;
    assign locked         = r_locked;
    assign done_flag      = r_done_flag;
    assign state          = r_state;
    assign verif_dividend = r_dividend;
    assign verif_divisor  = r_divisor;

endmodule

// File: tb/tb_div16by8.sv
// Directed plus random stimulus for div16by8, checked against plain-arithmetic division.
module tb_div16by8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        locked;
    logic        done_flag;
    logic        div_by_zero;
    logic [2:0]  state;
    logic [15:0] verif_dividend;
    logic [7:0]  verif_divisor;

    int n_checks = 0;
    int n_fail   = 0;

    div16by8 dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .dividend       (dividend),
        .divisor        (divisor),
        .quotient       (quotient),
        .remainder      (remainder),
        .locked         (locked),
        .done_flag      (done_flag),
        .div_by_zero    (div_by_zero),
        .state          (state),
        .verif_dividend (verif_dividend),
        .verif_divisor  (verif_divisor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV16BY8_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: ordinary integer division; a zero divisor gives all-ones and the low dividend byte.
    function automatic logic [23:0] ref_div(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] q;
        logic [15:0] r;
        if (b == 8'd0) begin
            q = 16'hFFFF;
            r = {8'd0, a[7:0]};
        end else begin
            q = a / {8'd0, b};
            r = a % {8'd0, b};
        end
        return {q, r[7:0]};
    endfunction

    function automatic int exp_latency(input logic [7:0] b);
        return (ZD && b == 8'd0) ? 0 : 16;
    endfunction

    // Starts one division and waits for done_flag; optionally disturbs the inputs mid-CALC.
    task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                           input bit interfere);
        int lat;
        bit seen;
        logic [23:0] exp;
        exp = ref_div(a, b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        check({tag, "_locked"}, locked, 1);
        seen = done_flag;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (interfere && lat == 5) begin
                dividend = ~a;
                divisor  = b ^ 8'h5A;
                start    = 1'b1;
            end
            if (interfere && lat == 7) begin
                start = 1'b0;
                check({tag, "_verif_dvd"}, verif_dividend, a);
                check({tag, "_verif_dvs"}, verif_divisor, b);
            end
            seen = done_flag;
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, lat, exp_latency(b));
        check({tag, "_quot"}, quotient, exp[23:8]);
        check({tag, "_rem"}, remainder, exp[7:0]);
        check({tag, "_dbz"}, div_by_zero, (ZD && b == 8'd0));
        check({tag, "_verif_dvd"}, verif_dividend, a);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done_flag, 0);
        check({tag, "_unlocked"}, locked, 0);
        check({tag, "_idle"}, state, 0);
        check({tag, "_hold_q"}, quotient, exp[23:8]);
    endtask

    initial begin
        int lat;
        bit seen;
        logic [15:0] ra;
        logic [7:0]  rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        #23;
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_locked", locked, 0);
        check("rst_done", done_flag, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_state", state, 0);
        @(negedge clk);
        rst = 1'b0;

        run_div("nominal", 16'd39483, 8'd200, 1'b0);
        run_div("div1", 16'hFFFF, 8'd1, 1'b0);
        run_div("exact", 16'hFFFF, 8'hFF, 1'b0);
        run_div("small", 16'd100, 8'd255, 1'b0);
        run_div("zero", 16'd1234, 8'd0, 1'b0);
        run_div("interf", 16'd50000, 8'd77, 1'b1);

        // start held high: back-to-back operations 18 cycles apart
        @(negedge clk);
        dividend = 16'd500;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        lat  = 0;
        seen = done_flag;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            seen = done_flag;
        end
        check("held_first_lat", lat, 16);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            seen = done_flag;
        end
        start = 1'b0;
        check("held_period", lat, 18);
        check("held_quot", quotient, 71);
        check("held_rem", remainder, 3);
        repeat (3) @(posedge clk);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        dividend = 16'd40000;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_quot", quotient, 0);
        check("mid_rst_rem", remainder, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_state", state, 0);
        check("mid_rst_vdvd", verif_dividend, 0);
        check("mid_rst_vdvs", verif_divisor, 0);
        @(negedge clk);
        rst = 1'b0;
        run_div("after_rst", 16'd500, 8'd7, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = (i % 8 == 3) ? 8'd0 : 8'($urandom);
            run_div("rand", ra, rb, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
